// File: rtl/csr_unit.sv
`default_nettype none
// ============================================================================
// Module   : csr_unit
// Brief    : Machine-mode CSR file: read-modify-write access, 64-bit cycle
//            and instret counters, trap entry / mret sequencing, interrupt
//            pending tracking, vectored trap target and illegal-access flag.
// Revision : 1.0 - initial release
// ============================================================================
module csr_unit #(
  parameter int              XLEN      = 32,  // 32 or 64 only
  parameter int              HARTID    = 0,
  parameter logic [XLEN-1:0] MTVEC_RST = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            csr_valid_i,
  input  logic [1:0]      csr_op_i,
  input  logic [11:0]     csr_addr_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  output logic [XLEN-1:0] csr_rdata_o,
  output logic            csr_illegal_o,
  input  logic            retire_i,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_cause_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic [XLEN-1:0] trap_val_i,
  input  logic            mret_i,
  input  logic            irq_sw_i,
  input  logic            irq_timer_i,
  input  logic            irq_ext_i,
  output logic [XLEN-1:0] mtvec_o,
  output logic [XLEN-1:0] mepc_o,
  output logic [XLEN-1:0] trap_target_o,
  output logic            irq_pending_o
);

  localparam logic        c_IS32       = (XLEN == 32);
  localparam logic [1:0]  c_OP_RW      = 2'b01;
  localparam logic [1:0]  c_OP_RS      = 2'b10;
  localparam logic [1:0]  c_OP_RC      = 2'b11;
  localparam logic [XLEN-1:0] c_MTVEC_MASK = ~XLEN'(2);  // bit1 hardwired 0
  localparam logic [XLEN-1:0] c_MEPC_MASK  = ~XLEN'(3);  // bits[1:0] hardwired 0

  localparam logic [11:0] c_MSTATUS   = 12'h300;
  localparam logic [11:0] c_MIE       = 12'h304;
  localparam logic [11:0] c_MTVEC     = 12'h305;
  localparam logic [11:0] c_MSCRATCH  = 12'h340;
  localparam logic [11:0] c_MEPC      = 12'h341;
  localparam logic [11:0] c_MCAUSE    = 12'h342;
  localparam logic [11:0] c_MTVAL     = 12'h343;
  localparam logic [11:0] c_MIP       = 12'h344;
  localparam logic [11:0] c_MCYCLE    = 12'hB00;
  localparam logic [11:0] c_MINSTRET  = 12'hB02;
  localparam logic [11:0] c_MCYCLEH   = 12'hB80;
  localparam logic [11:0] c_MINSTRETH = 12'hB82;
  localparam logic [11:0] c_CYCLE     = 12'hC00;
  localparam logic [11:0] c_INSTRET   = 12'hC02;
  localparam logic [11:0] c_CYCLEH    = 12'hC80;
  localparam logic [11:0] c_INSTRETH  = 12'hC82;
  localparam logic [11:0] c_MHARTID   = 12'hF14;

  // Architectural state; mie is kept as its three implemented bits {11,7,3}
  logic            r_mst_mie;
  logic            r_mst_mpie;
  logic [2:0]      r_mie;
  logic [XLEN-1:0] r_mtvec;
  logic [XLEN-1:0] r_mscratch;
  logic [XLEN-1:0] r_mepc;
  logic [XLEN-1:0] r_mcause;
  logic [XLEN-1:0] r_mtval;
  logic [63:0]     r_mcycle;
  logic [63:0]     r_minstret;

  logic [XLEN-1:0] w_mstatus;
  logic [XLEN-1:0] w_mie_full;
  logic [XLEN-1:0] w_mip_full;
  logic [2:0]      w_mip;
  logic [XLEN-1:0] w_rdata;
  logic            w_mapped;
  logic            w_ro;
  logic [XLEN-1:0] w_new;
  logic            w_wr_req;
  logic            w_illegal;
  logic            w_we;
  logic [63:0]     w_mcycle_nxt;
  logic [63:0]     w_minstret_nxt;
  logic [XLEN-1:0] w_tvec_base;

  assign w_mip = {irq_ext_i, irq_timer_i, irq_sw_i};

  // Expand the sparse registers into their architectural read views
  always_comb begin
    w_mstatus         = '0;
    w_mstatus[12:11]  = 2'b11;
    w_mstatus[7]      = r_mst_mpie;
    w_mstatus[3]      = r_mst_mie;
    w_mie_full        = '0;
    w_mie_full[11]    = r_mie[2];
    w_mie_full[7]     = r_mie[1];
    w_mie_full[3]     = r_mie[0];
    w_mip_full        = '0;
    w_mip_full[11]    = w_mip[2];
    w_mip_full[7]     = w_mip[1];
    w_mip_full[3]     = w_mip[0];
  end

  // Address decode: read value, mapped and read-only flags
  always_comb begin
    w_rdata  = '0;
    w_mapped = 1'b1;
    w_ro     = 1'b0;
    case (csr_addr_i)
      c_MSTATUS:  w_rdata = w_mstatus;
      c_MIE:      w_rdata = w_mie_full;
      c_MTVEC:    w_rdata = r_mtvec;
      c_MSCRATCH: w_rdata = r_mscratch;
      c_MEPC:     w_rdata = r_mepc;
      c_MCAUSE:   w_rdata = r_mcause;
      c_MTVAL:    w_rdata = r_mtval;
      c_MIP: begin
        w_rdata = w_mip_full;
        w_ro    = 1'b1;
      end
      c_MCYCLE:   w_rdata = XLEN'(r_mcycle);
      c_MINSTRET: w_rdata = XLEN'(r_minstret);
      c_MCYCLEH: begin
        if (c_IS32) w_rdata = XLEN'(r_mcycle[63:32]);
        else        w_mapped = 1'b0;
      end
      c_MINSTRETH: begin
        if (c_IS32) w_rdata = XLEN'(r_minstret[63:32]);
        else        w_mapped = 1'b0;
      end
      c_CYCLE: begin
        w_rdata = XLEN'(r_mcycle);
        w_ro    = 1'b1;
      end
      c_INSTRET: begin
        w_rdata = XLEN'(r_minstret);
        w_ro    = 1'b1;
      end
      c_CYCLEH: begin
        w_ro = 1'b1;
        if (c_IS32) w_rdata = XLEN'(r_mcycle[63:32]);
        else        w_mapped = 1'b0;
      end
      c_INSTRETH: begin
        w_ro = 1'b1;
        if (c_IS32) w_rdata = XLEN'(r_minstret[63:32]);
        else        w_mapped = 1'b0;
      end
      c_MHARTID: begin
        w_rdata = XLEN'(HARTID);
        w_ro    = 1'b1;
      end
      default:    w_mapped = 1'b0;
    endcase
  end

  // Read-modify-write value and write/illegal qualification
  always_comb begin
    w_new = w_rdata;
    case (csr_op_i)
      c_OP_RW: w_new = csr_wdata_i;
      c_OP_RS: w_new = w_rdata | csr_wdata_i;
      c_OP_RC: w_new = w_rdata & ~csr_wdata_i;
      default: w_new = w_rdata;
    endcase
    // Set/clear with a zero mask is a pure read and may target read-only CSRs
    w_wr_req  = csr_valid_i && (csr_op_i != 2'b00) &&
                !(csr_op_i[1] && (csr_wdata_i == '0));
    w_illegal = csr_valid_i && (!w_mapped || (w_wr_req && w_ro));
    w_we      = w_wr_req && !w_illegal;
  end

  // Counter next values: a CSR write replaces only the written half
  always_comb begin
    w_mcycle_nxt   = r_mcycle + 64'd1;
    w_minstret_nxt = r_minstret + {63'd0, retire_i};
    if (w_we) begin
      case (csr_addr_i)
        c_MCYCLE: begin
          if (c_IS32) w_mcycle_nxt[31:0] = w_new[31:0];
          else        w_mcycle_nxt       = 64'(w_new);
        end
        c_MCYCLEH:   w_mcycle_nxt[63:32] = w_new[31:0];
        c_MINSTRET: begin
          if (c_IS32) w_minstret_nxt[31:0] = w_new[31:0];
          else        w_minstret_nxt       = 64'(w_new);
        end
        c_MINSTRETH: w_minstret_nxt[63:32] = w_new[31:0];
        default: ;
      endcase
    end
  end

  // State update: reset, then trap > mret > CSR write per register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mst_mie  <= 1'b0;
      r_mst_mpie <= 1'b0;
      r_mie      <= '0;
      r_mtvec    <= MTVEC_RST & c_MTVEC_MASK;
      r_mscratch <= '0;
      r_mepc     <= '0;
      r_mcause   <= '0;
      r_mtval    <= '0;
      r_mcycle   <= '0;
      r_minstret <= '0;
    end else begin
      r_mcycle   <= w_mcycle_nxt;
      r_minstret <= w_minstret_nxt;

      if (trap_i) begin
        r_mst_mpie <= r_mst_mie;
        r_mst_mie  <= 1'b0;
      end else if (mret_i) begin
        r_mst_mie  <= r_mst_mpie;
        r_mst_mpie <= 1'b1;
      end else if (w_we && csr_addr_i == c_MSTATUS) begin
        r_mst_mie  <= w_new[3];
        r_mst_mpie <= w_new[7];
      end

      if (trap_i) begin
        r_mepc   <= trap_pc_i & c_MEPC_MASK;
        r_mcause <= trap_cause_i;
        r_mtval  <= trap_val_i;
      end else if (w_we) begin
        if (csr_addr_i == c_MEPC)   r_mepc   <= w_new & c_MEPC_MASK;
        if (csr_addr_i == c_MCAUSE) r_mcause <= w_new;
        if (csr_addr_i == c_MTVAL)  r_mtval  <= w_new;
      end

      if (w_we && csr_addr_i == c_MIE)      r_mie      <= {w_new[11], w_new[7], w_new[3]};
      if (w_we && csr_addr_i == c_MTVEC)    r_mtvec    <= w_new & c_MTVEC_MASK;
      if (w_we && csr_addr_i == c_MSCRATCH) r_mscratch <= w_new;
    end
  end

  // Handler address: vectored mode offsets interrupts by 4*cause
  always_comb begin
    w_tvec_base   = {r_mtvec[XLEN-1:2], 2'b00};
    trap_target_o = w_tvec_base;
    if (r_mtvec[0] && trap_cause_i[XLEN-1])
      trap_target_o = w_tvec_base + {trap_cause_i[XLEN-3:0], 2'b00};
  end

  assign csr_rdata_o   = w_rdata;
  assign csr_illegal_o = w_illegal;
  assign mtvec_o       = r_mtvec;
  assign mepc_o        = r_mepc;
  assign irq_pending_o = r_mst_mie && |(r_mie & w_mip);

endmodule
`default_nettype wire

// File: tb/tb_csr_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_csr_unit
// Brief    : Self-checking bench for csr_unit (XLEN=32) with an expectation
//            queue drained at the falling edge of each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csr_unit;

  localparam int          c_XLEN   = 32;
  localparam int          c_HARTID = 3;
  localparam logic [31:0] c_TVRST  = 32'h0000_0100;

  localparam int S_RD = 0, S_ILL = 1, S_TGT = 2, S_PEND = 3, S_MEPC = 4, S_MTVEC = 5;

  logic        clk, rst;
  logic        csr_valid_i;
  logic [1:0]  csr_op_i;
  logic [11:0] csr_addr_i;
  logic [31:0] csr_wdata_i, csr_rdata_o;
  logic        csr_illegal_o;
  logic        retire_i, trap_i, mret_i;
  logic [31:0] trap_cause_i, trap_pc_i, trap_val_i;
  logic        irq_sw_i, irq_timer_i, irq_ext_i;
  logic [31:0] mtvec_o, mepc_o, trap_target_o;
  logic        irq_pending_o;

  csr_unit #(.XLEN(c_XLEN), .HARTID(c_HARTID), .MTVEC_RST(c_TVRST)) u_dut (
    .clk(clk), .rst(rst),
    .csr_valid_i(csr_valid_i), .csr_op_i(csr_op_i), .csr_addr_i(csr_addr_i),
    .csr_wdata_i(csr_wdata_i), .csr_rdata_o(csr_rdata_o), .csr_illegal_o(csr_illegal_o),
    .retire_i(retire_i), .trap_i(trap_i), .trap_cause_i(trap_cause_i),
    .trap_pc_i(trap_pc_i), .trap_val_i(trap_val_i), .mret_i(mret_i),
    .irq_sw_i(irq_sw_i), .irq_timer_i(irq_timer_i), .irq_ext_i(irq_ext_i),
    .mtvec_o(mtvec_o), .mepc_o(mepc_o), .trap_target_o(trap_target_o),
    .irq_pending_o(irq_pending_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] expv;
  } exp_t;

  exp_t        r_sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] m_cyc = '0;
  logic [63:0] m_ins = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  task automatic expect_out(input string tag, input int sel, input logic [31:0] expv);
    exp_t e;
    e.tag  = tag;
    e.sel  = sel;
    e.expv = expv;
    r_sb.push_back(e);
  endtask

  // Drain expectations mid-cycle, then advance one edge and the counter model
  task automatic step();
    exp_t        e;
    logic [31:0] obs;
    @(negedge clk);
    while (r_sb.size() > 0) begin
      e = r_sb.pop_front();
      case (e.sel)
        S_RD:    obs = csr_rdata_o;
        S_ILL:   obs = {31'd0, csr_illegal_o};
        S_TGT:   obs = trap_target_o;
        S_PEND:  obs = {31'd0, irq_pending_o};
        S_MEPC:  obs = mepc_o;
        default: obs = mtvec_o;
      endcase
      chk(e.tag, obs, e.expv);
    end
    @(posedge clk);
    if (rst) begin
      m_cyc = '0;
      m_ins = '0;
    end else begin
      m_cyc = m_cyc + 64'd1;
      m_ins = m_ins + {63'd0, retire_i};
    end
    #1;
  endtask

  task automatic csr(input string tag, input logic [1:0] op, input logic [11:0] addr,
                     input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_ill);
    csr_valid_i = 1'b1;
    csr_op_i    = op;
    csr_addr_i  = addr;
    csr_wdata_i = wd;
    expect_out({tag, "_rdata"}, S_RD, exp_rd);
    expect_out({tag, "_illegal"}, S_ILL, {31'd0, exp_ill});
    step();
    csr_valid_i = 1'b0;
    csr_op_i    = 2'b00;
    csr_wdata_i = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; csr_valid_i = 1'b0; csr_op_i = 2'b00; csr_addr_i = '0; csr_wdata_i = '0;
    retire_i = 1'b0; trap_i = 1'b0; mret_i = 1'b0;
    trap_cause_i = '0; trap_pc_i = '0; trap_val_i = '0;
    irq_sw_i = 1'b0; irq_timer_i = 1'b0; irq_ext_i = 1'b0;
    repeat (2) step();
    rst = 1'b0;

    // Reset outputs, then 10 cycles with 4 retire pulses
    for (int i = 0; i < 10; i++) begin
      retire_i = (i % 3 == 0);
      if (i == 0) begin
        expect_out("rst_mepc_o", S_MEPC, 32'h0);
        expect_out("rst_mtvec_o", S_MTVEC, c_TVRST);
        expect_out("rst_pending", S_PEND, 32'h0);
      end
      step();
    end
    retire_i = 1'b0;
    csr("mcycle_10",   2'b00, 12'hB00, 32'h0, 32'd10, 1'b0);
    csr("minstret_4",  2'b00, 12'hB02, 32'h0, 32'd4, 1'b0);
    csr("mstatus_rst", 2'b00, 12'h300, 32'h0, 32'h1800, 1'b0);
    csr("mhartid",     2'b00, 12'hF14, 32'h0, c_HARTID, 1'b0);
    csr("cycle_rs0",   2'b10, 12'hC00, 32'h0, m_cyc[31:0], 1'b0);

    // Vectored mtvec and trap target
    csr("mtvec_rw", 2'b01, 12'h305, 32'h8000_0001, c_TVRST, 1'b0);
    csr("mtvec_rd", 2'b00, 12'h305, 32'h0, 32'h8000_0001, 1'b0);
    trap_cause_i = 32'h8000_0007;
    expect_out("target_irq7", S_TGT, 32'h8000_001C);
    expect_out("mtvec_o", S_MTVEC, 32'h8000_0001);
    step();
    trap_cause_i = 32'h2;
    expect_out("target_exc2", S_TGT, 32'h8000_0000);
    step();

    // mstatus set, trap entry, mret
    csr("mstatus_rs", 2'b10, 12'h300, 32'h8, 32'h1800, 1'b0);
    csr("mstatus_mie", 2'b00, 12'h300, 32'h0, 32'h1808, 1'b0);
    trap_i = 1'b1; trap_pc_i = 32'h103; trap_cause_i = 32'h2; trap_val_i = 32'hDEAD;
    step();
    trap_i = 1'b0;
    expect_out("trap_mepc_o", S_MEPC, 32'h100);
    csr("trap_mepc",    2'b00, 12'h341, 32'h0, 32'h100, 1'b0);
    csr("trap_mstatus", 2'b00, 12'h300, 32'h0, 32'h1880, 1'b0);
    csr("trap_mcause",  2'b00, 12'h342, 32'h0, 32'h2, 1'b0);
    csr("trap_mtval",   2'b00, 12'h343, 32'h0, 32'hDEAD, 1'b0);
    mret_i = 1'b1;
    step();
    mret_i = 1'b0;
    csr("mret_mstatus", 2'b00, 12'h300, 32'h0, 32'h1888, 1'b0);

    // Counter halves and 64-bit wrap
    csr("mcycleh_rw", 2'b01, 12'hB80, 32'hFFFF_FFFF, m_cyc[63:32], 1'b0);
    m_cyc[63:32] = 32'hFFFF_FFFF;
    csr("mcycle_rw", 2'b01, 12'hB00, 32'hFFFF_FFFE, m_cyc[31:0], 1'b0);
    m_cyc[31:0] = 32'hFFFF_FFFE;
    step();
    step();
    csr("wrap_lo", 2'b00, 12'hB00, 32'h0, 32'h0, 1'b0);
    csr("wrap_hi", 2'b00, 12'hB80, 32'h0, 32'h0, 1'b0);

    // Illegal accesses
    csr("cycle_rw_ill",    2'b01, 12'hC00, 32'h1234, m_cyc[31:0], 1'b1);
    csr("mcycle_unchanged",2'b00, 12'hB00, 32'h0, m_cyc[31:0], 1'b0);
    csr("cycle_rs0_legal", 2'b10, 12'hC00, 32'h0, m_cyc[31:0], 1'b0);
    csr("mhartid_wr_ill",  2'b01, 12'hF14, 32'h5, c_HARTID, 1'b1);
    csr("mip_wr_ill",      2'b01, 12'h344, 32'hFFF, 32'h0, 1'b1);
    csr("mscratch_pre",    2'b00, 12'h340, 32'h0, 32'h0, 1'b0);
    csr_valid_i = 1'b1; csr_op_i = 2'b00; csr_addr_i = 12'h7C0;
    expect_out("unmapped_7c0", S_ILL, 32'h1);
    step();
    csr_valid_i = 1'b0;
    csr("mstatus_after_ill", 2'b01, 12'hC02, 32'h0, m_ins[31:0], 1'b1);
    csr("mstatus_still",     2'b00, 12'h300, 32'h0, 32'h1888, 1'b0);

    // Interrupt pending
    csr("mie_rw_all", 2'b01, 12'h304, 32'hFFFF_FFFF, 32'h0, 1'b0);
    csr("mie_warl",   2'b00, 12'h304, 32'h0, 32'h888, 1'b0);
    csr("mie_rw80",   2'b01, 12'h304, 32'h80, 32'h888, 1'b0);
    irq_sw_i = 1'b1;
    expect_out("pend_sw_masked", S_PEND, 32'h0);
    step();
    irq_sw_i = 1'b0;
    irq_timer_i = 1'b1;
    expect_out("pend_timer", S_PEND, 32'h1);
    csr("mip_rd", 2'b00, 12'h344, 32'h0, 32'h80, 1'b0);
    expect_out("pend_during_rc", S_PEND, 32'h1);
    csr("mstatus_rc", 2'b11, 12'h300, 32'h8, 32'h1888, 1'b0);
    expect_out("pend_after_rc", S_PEND, 32'h0);
    step();
    irq_timer_i = 1'b0;

    // Same-cycle collisions
    trap_i = 1'b1; trap_pc_i = 32'h204; trap_cause_i = 32'hB; trap_val_i = 32'h0;
    csr("mepc_wr_trap", 2'b01, 12'h341, 32'h40, 32'h100, 1'b0);
    trap_i = 1'b0;
    csr("mepc_trap_wins", 2'b00, 12'h341, 32'h0, 32'h204, 1'b0);
    trap_i = 1'b1; trap_pc_i = 32'h208;
    csr("mscratch_wr_trap", 2'b01, 12'h340, 32'h55, 32'h0, 1'b0);
    trap_i = 1'b0;
    csr("mscratch_lands", 2'b00, 12'h340, 32'h0, 32'h55, 1'b0);

    // Reset wins over a simultaneous trap
    rst = 1'b1; trap_i = 1'b1; trap_pc_i = 32'h400;
    step();
    rst = 1'b0; trap_i = 1'b0;
    irq_timer_i = 1'b1;
    expect_out("rst2_mepc_o", S_MEPC, 32'h0);
    expect_out("rst2_mtvec_o", S_MTVEC, c_TVRST);
    expect_out("rst2_pending", S_PEND, 32'h0);
    csr("rst2_mcycle",   2'b00, 12'hB00, 32'h0, 32'h0, 1'b0);
    csr("rst2_mepc",     2'b00, 12'h341, 32'h0, 32'h0, 1'b0);
    csr("rst2_mstatus",  2'b00, 12'h300, 32'h0, 32'h1800, 1'b0);
    csr("rst2_mscratch", 2'b00, 12'h340, 32'h0, 32'h0, 1'b0);
    csr("rst2_mie",      2'b00, 12'h304, 32'h0, 32'h0, 1'b0);
    csr("rst2_mcause",   2'b00, 12'h342, 32'h0, 32'h0, 1'b0);
    irq_timer_i = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
